bcd_to_bin_converter: RTL and testbench
=======================================

Name: bcd_to_bin_converter

Overview:
- Sequential reverse double-dabble converter: takes a 5-digit packed BCD value (D5 = most significant) and produces its binary equivalent.
- It is the inverse of the design's binary-to-BCD display path. Use it to turn entered or displayed digit values back into a binary hash or ID for comparison and checking.
- One bit is resolved per clock, so a conversion takes BIN_W shift cycles.
- start/busy/done handshake; invalid digits are flagged, not converted.

Parameters:
- DIGITS, 5, number of BCD digits in bcd_in.
- BIN_W, 17, binary result width. Must satisfy 10^DIGITS - 1 < 2^BIN_W; 17 covers 99999.

Ports:
- sysclk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  conversion request; sampled only in IDLE.
- bcd_in  input  4*DIGITS  packed digits; [4*DIGITS-1:4*DIGITS-4] = D5, [3:0] = D1.
- busy  output  1  high while a conversion is in progress (SHIFT state).
- done  output  1  one-cycle pulse when the result and err are valid.
- err  output  1  set if any latched digit > 9; held until the next accepted start.
- bin_out  output  BIN_W  converted value; held until the next accepted start.

Behaviour:
- Reset (sampled high on a sysclk edge):
  - state = IDLE; busy = 0, done = 0, err = 0, bin_out = 0; internal shift register and counter cleared.
  - Reset has priority over every other event, including mid-conversion. An in-flight conversion is abandoned and no done pulse is produced.
- States: IDLE, SHIFT, DONE.
- IDLE, start = 1 at edge k:
  - Latch bcd_in into the BCD register; clear the binary accumulator; clear err; clear bin_out to 0.
  - If any latched nibble > 9: go to DONE with err = 1 and bin_out = 0. done is high in the cycle after edge k+1.
  - Otherwise: go to SHIFT with counter = 0 and busy = 1.
- SHIFT, each edge:
  - Shift the concatenation {bcd_reg, bin_acc} right by 1 bit.
  - Then, for every 4-bit BCD nibble whose value is >= 8, subtract 3 from that nibble. Nibbles are corrected independently, within the same cycle.
  - Increment the counter.
  - On the edge where counter reaches BIN_W - 1 (the BIN_W-th shift): bin_out <= post-shift bin_acc; go to DONE.
- DONE:
  - done = 1 and busy = 0 for exactly one cycle, then unconditionally IDLE.
  - start during DONE is ignored.
- Latency for a valid input: start accepted at edge k.
  - busy is high in cycles k+1 .. k+BIN_W.
  - done is high in the cycle after edge k+BIN_W, i.e. 17 cycles of busy, then the done cycle.
  - Next start is accepted at the edge after the done cycle, giving a throughput of one conversion per BIN_W + 2 cycles.
- start while busy or in DONE: ignored; no effect on the current result.
- bcd_in changes after acceptance: no effect (the value was latched).
- bin_out and err are stable from the done cycle until the next accepted start. On acceptance they clear to 0.
- After the final shift the BCD register is 0 for a valid input. The bench may check this via hierarchy; it is not a port.
- Arithmetic: nibble correction operates on 4-bit unsigned values with no carry between nibbles. The maximum result is 99999 = 17'h1869F, with no overflow for the default parameters.

Test Plan:
- Reset, then start with bcd_in = 20'h00000 -> busy high for 17 cycles; done pulse; bin_out = 0; err = 0.
- bcd_in = 20'h12345, start at edge k -> done high only in the cycle after edge k+17; bin_out = 12345 (17'h03039); busy low in the done cycle.
- bcd_in = 20'h99999 -> bin_out = 99999 (17'h1869F). Then 20'h65535 -> bin_out = 65535.
- bcd_in = 20'h1A345 (D4 = 0xA) -> done in the cycle after edge k+1; err = 1; bin_out = 0; busy never asserted. A following valid start clears err.
- During a 20'h00042 conversion, pulse start with 20'h99999 while busy and again in the done cycle -> both ignored; bin_out = 42; exactly one done pulse.
- Assert reset on the 8th SHIFT cycle of 20'h54321 -> next cycle: busy = 0, done = 0, bin_out = 0, state IDLE; no later done pulse. A fresh start with 20'h00007 gives bin_out = 7.

Source files
------------

// File: rtl/bcd_to_bin_converter.sv
// bcd_to_bin_converter
//   Sequential reverse double-dabble: converts a DIGITS-digit packed BCD value
//   into binary, resolving one result bit per clock (BIN_W shift cycles).
//
// Ports
//   sysclk   in   system clock, rising edge
//   reset    in   synchronous active-high reset
//   start    in   conversion request, sampled only in IDLE
//   bcd_in   in   packed digits, most significant digit in the top nibble
//   busy     out  high while shifting
//   done     out  one-cycle pulse when bin_out/err are valid
//   err      out  a latched digit was > 9; held until the next accepted start
//   bin_out  out  converted value; held until the next accepted start
module bcd_to_bin_converter #(
  parameter int DIGITS = 5,
  parameter int BIN_W  = 17
) (
  input  logic                  sysclk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [BIN_W-1:0]      bin_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e             state_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [BIN_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic [BIN_W-1:0]   bin_q;

  logic [BCD_W-1:0]   bcd_d;
  logic [BIN_W-1:0]   acc_d;
  logic               bad_digit;

  // One shift step: move the pair right by one, then pull each nibble that
  // landed at >= 8 back down by 3 (undoes the x2 carry of a decimal digit).
  always_comb begin
    {bcd_d, acc_d} = {bcd_q, acc_q} >> 1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_d[4*i +: 4] >= 4'd8) begin
        bcd_d[4*i +: 4] = bcd_d[4*i +: 4] - 4'd3;
      end
    end
  end

  always_comb begin
    bad_digit = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) begin
        bad_digit = 1'b1;
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q <= S_IDLE;
      bcd_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      bin_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            bcd_q <= bcd_in;
            acc_q <= '0;
            cnt_q <= '0;
            bin_q <= '0;
            err_q <= bad_digit;
            if (bad_digit) begin
              busy_q  <= 1'b0;
              state_q <= S_DONE;
            end else begin
              busy_q  <= 1'b1;
              state_q <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          bcd_q <= bcd_d;
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            bin_q   <= acc_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          // The error path enters DONE with done_q low, so it spends one
          // extra cycle here and pulses done in the cycle after edge k+1.
          if (done_q) begin
            done_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign bin_out = bin_q;

endmodule

// File: tb/tb_bcd_to_bin_converter.sv
module tb_bcd_to_bin_converter;

  localparam int DIGITS = 5;
  localparam int BW     = 17;

  logic              sysclk;
  logic              reset;
  logic              start;
  logic [19:0]       bcd_in;
  logic              busy;
  logic              done;
  logic              err;
  logic [BW-1:0]     bin_out;

  int checks = 0;
  int errors = 0;

  bcd_to_bin_converter #(.DIGITS(DIGITS), .BIN_W(BW)) dut (
    .sysclk  (sysclk),
    .reset   (reset),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .bin_out (bin_out)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  // Reference: decimal value of the digits, and digit validity.
  function automatic int model_val(input logic [19:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic bit model_bad(input logic [19:0] v);
    bit b = 0;
    for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) b = 1;
    return b;
  endfunction

  function automatic logic [19:0] rand_valid();
    logic [19:0] v;
    for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // Drives one conversion; c counts cycles after the accepting edge k
  // (c = n means the cycle after edge k+n). Returns at the cycle after done.
  task automatic do_conv(input logic [19:0] v, input bit noise,
                         output int first, output int busy_cnt, output int pulses,
                         output logic [BW-1:0] bo, output logic e,
                         output logic busy_at_done, output logic [19:0] bcd_left);
    first = -1; busy_cnt = 0; pulses = 0;
    bo = 'x; e = 1'bx; busy_at_done = 1'bx; bcd_left = 'x;
    bcd_in = v; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (busy) busy_cnt++;
      if (done) pulses++;
      if (done && first < 0) begin
        first = c; bo = bin_out; e = err; busy_at_done = busy; bcd_left = dut.bcd_q;
      end
      if (noise && c == 5) begin bcd_in = 20'h99999; start = 1'b1; end
      if (noise && c == 6) start = 1'b0;
      if (noise && first == c) start = 1'b1;
      if (first >= 0 && c == first + 1) begin start = 1'b0; break; end
      step();
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; bcd_in = '0;
    repeat (3) step();
    checks++;
    if ({busy, done, err} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got busy/done/err=%b required 000", {busy, done, err});
    end
    checks++;
    if (bin_out !== '0) begin
      errors++; $display("FAIL reset_bin: got %0d required 0", bin_out);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_valid(input logic [19:0] v, input string tag);
    int f, bc, p; logic [BW-1:0] bo; logic e, bd; logic [19:0] bl;
    do_conv(v, 0, f, bc, p, bo, e, bd, bl);
    checks++;
    if (f !== BW) begin
      errors++; $display("FAIL %s_latency (%h): done at c=%0d required %0d", tag, v, f, BW);
    end
    checks++;
    if (bc !== BW || p !== 1) begin
      errors++; $display("FAIL %s_busy_pulses (%h): busy=%0d done=%0d required %0d/1", tag, v, bc, p, BW);
    end
    checks++;
    if (bo !== BW'(model_val(v)) || e !== 1'b0 || bd !== 1'b0) begin
      errors++; $display("FAIL %s_result (%h): bin=%0d err=%b busy=%b required %0d 0 0",
                         tag, v, bo, e, bd, model_val(v));
    end
    checks++;
    if (bl !== 20'h0) begin
      errors++; $display("FAIL %s_bcd_residue (%h): got %h required 0", tag, v, bl);
    end
    checks++;
    if (bin_out !== BW'(model_val(v)) || done !== 1'b0) begin
      errors++; $display("FAIL %s_hold (%h): bin=%0d done=%b required %0d 0", tag, v, bin_out, done, model_val(v));
    end
  endtask

  task automatic test_invalid(input logic [19:0] v);
    int f, bc, p; logic [BW-1:0] bo; logic e, bd; logic [19:0] bl;
    do_conv(v, 0, f, bc, p, bo, e, bd, bl);
    checks++;
    if (f !== 1 || bc !== 0 || p !== 1) begin
      errors++; $display("FAIL invalid_timing (%h): done c=%0d busy=%0d pulses=%0d required 1 0 1", v, f, bc, p);
    end
    checks++;
    if (e !== model_bad(v) || bo !== '0) begin
      errors++; $display("FAIL invalid_result (%h): err=%b bin=%0d required 1 0", v, e, bo);
    end
  endtask

  task automatic test_random();
    logic [19:0] v;
    for (int n = 0; n < 12; n++) begin
      v = rand_valid();
      test_valid(v, "random");
    end
    for (int n = 0; n < 4; n++) begin
      v = rand_valid();
      v[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
      test_invalid(v);
    end
  endtask

  task automatic test_err_clear();
    test_invalid(20'h1A345);
    test_valid(20'h00300, "err_clear");
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL err_clear: err=%b required 0", err);
    end
  endtask

  task automatic test_ignore_start();
    int f, bc, p, extra; logic [BW-1:0] bo; logic e, bd; logic [19:0] bl;
    do_conv(20'h00042, 1, f, bc, p, bo, e, bd, bl);
    checks++;
    if (f !== BW || p !== 1 || bo !== BW'(42)) begin
      errors++; $display("FAIL ignore_start: done c=%0d pulses=%0d bin=%0d required %0d 1 42", f, p, bo, BW);
    end
    extra = 0;
    for (int c = 0; c < 25; c++) begin
      if (done || busy) extra++;
      step();
    end
    checks++;
    if (extra !== 0 || bin_out !== BW'(42)) begin
      errors++; $display("FAIL ignore_start_after: activity=%0d bin=%0d required 0 42", extra, bin_out);
    end
  endtask

  task automatic test_reset_mid();
    int extra;
    bcd_in = 20'h54321; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 7; c++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({busy, done, err} !== 3'b000 || bin_out !== '0 || dut.state_q !== 2'd0) begin
      errors++; $display("FAIL reset_mid: busy/done/err=%b bin=%0d state=%0d required 000 0 0",
                         {busy, done, err}, bin_out, dut.state_q);
    end
    extra = 0;
    for (int c = 0; c < 25; c++) begin
      if (done || busy) extra++;
      step();
    end
    checks++;
    if (extra !== 0) begin
      errors++; $display("FAIL reset_mid_quiet: activity=%0d required 0", extra);
    end
    test_valid(20'h00007, "after_reset");
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; bcd_in = '0;
    test_reset();
    test_valid(20'h00000, "zero");
    test_valid(20'h12345, "d12345");
    test_valid(20'h99999, "max");
    test_valid(20'h65535, "d65535");
    test_err_clear();
    test_ignore_start();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
